// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared lock package: channel-state encoding and debounce defaults
// Used by key_debounce and debounce_channel; optional synchroniser selected by KEY_DEBOUNCE_SYNC_EN.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    CH_REL   = 2'b00,
    CH_PWAIT = 2'b01,
    CH_HELD  = 2'b10,
    CH_RWAIT = 2'b11
  } ch_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

  // Counter width; clamped to 1 so the smallest legal count still has a bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - one key channel: optional 2-flop synchroniser, run counter, 4-state FSM
// KEY_DEBOUNCE_SYNC_EN defined: btn passes through a 2-flop synchroniser; undefined: btn used directly.
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic       qualify,
  output logic [1:0] state
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic s;

`ifdef KEY_DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d = {sync_q[0], btn};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[1];
`else
  assign s = btn;
`endif

  ch_state_e     state_q;
  ch_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CH_REL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qualify = 1'b0;
    case (state_q)
      CH_REL: begin
        if (s) begin
          state_d = CH_PWAIT;
          cnt_d   = CNT_ONE;
        end
      end
      CH_PWAIT: begin
        if (!s) begin
          state_d = CH_REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CH_HELD;
          cnt_d   = '0;
          qualify = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CH_HELD: begin
        if (!s) begin
          state_d = CH_RWAIT;
          cnt_d   = CNT_ONE;
        end
      end
      CH_RWAIT: begin
        if (s) begin
          state_d = CH_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CH_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = CH_REL;
        cnt_d   = '0;
      end
    endcase
  end

  assign state = state_q;

  cnt_bound_a: assert property (@(posedge clk) disable iff (!reset) cnt_q <= CNT_LAST);

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-key debouncer with overlap arbitration producing w0/w1/conflict strobes
// KEY_DEBOUNCE_SYNC_EN selects the per-key 2-flop synchroniser inside debounce_channel.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn0,
  input  logic btn1,
  output logic w0,
  output logic w1,
  output logic conflict
);

  logic       qual0;
  logic       qual1;
  logic [1:0] state0;
  logic [1:0] state1;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch0 (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn0),
    .qualify(qual0),
    .state  (state0)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn1),
    .qualify(qual1),
    .state  (state1)
  );

  logic busy0;
  logic busy1;
  logic w0_d;
  logic w1_d;
  logic conflict_d;
  logic w0_q;
  logic w1_q;
  logic conflict_q;

  assign busy0 = (state0 != CH_REL);
  assign busy1 = (state1 != CH_REL);

  // A press wins only if the other key is fully released; otherwise it is dropped, not deferred.
  always_comb begin
    w0_d       = 1'b0;
    w1_d       = 1'b0;
    conflict_d = 1'b0;
    if (qual0 && qual1) begin
      conflict_d = 1'b1;
    end else if (qual0) begin
      w0_d       = !busy1;
      conflict_d = busy1;
    end else if (qual1) begin
      w1_d       = !busy0;
      conflict_d = busy0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w0_q       <= 1'b0;
      w1_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      conflict_q <= conflict_d;
    end
  end

  assign w0       = w0_q;
  assign w1       = w1_q;
  assign conflict = conflict_q;

  excl_a: assert property (@(posedge clk) disable iff (!reset) $onehot0({w0_q, w1_q, conflict_q}));

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce (follows KEY_DEBOUNCE_SYNC_EN)
// Run-length reference model, vector table, latency/reset sequences and random stimulus.
module tb_key_debounce;

  localparam int N = 4;
`ifdef KEY_DEBOUNCE_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn0 = 1'b0;
  logic btn1 = 1'b0;
  logic w0;
  logic w1;
  logic conflict;

  key_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn0    (btn0),
    .btn1    (btn1),
    .w0      (w0),
    .w1      (w1),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: accepted level per key plus length of the current run disagreeing with it.
  bit m_pipe0[2];
  bit m_pipe1[2];
  bit m_level[2];
  int m_run[2];
  bit m_w0, m_w1, m_c;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit raw[2];
    bit s[2];
    bit q[2];
    bit busy[2];
    bit n_level[2];
    int n_run[2];
    bit n_w0, n_w1, n_c;
    bit rst_n;
    raw[0] = btn0;
    raw[1] = btn1;
    rst_n  = reset;
    for (int ch = 0; ch < 2; ch++) begin
      s[ch]    = (SYNC != 0) ? m_pipe1[ch] : raw[ch];
      q[ch]    = !m_level[ch] && s[ch] && (m_run[ch] == N - 1);
      busy[ch] = m_level[ch] || (m_run[ch] != 0);
      n_level[ch] = m_level[ch];
      n_run[ch]   = 0;
      if (s[ch] != m_level[ch]) begin
        if (m_run[ch] == N - 1) n_level[ch] = s[ch];
        else n_run[ch] = m_run[ch] + 1;
      end
    end
    n_w0 = q[0] && !q[1] && !busy[1];
    n_w1 = q[1] && !q[0] && !busy[0];
    n_c  = (q[0] && q[1]) || (q[0] && busy[1]) || (q[1] && busy[0]);
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      m_pipe1[ch] = rst_n ? m_pipe0[ch] : 1'b0;
      m_pipe0[ch] = rst_n ? raw[ch] : 1'b0;
      m_level[ch] = rst_n ? n_level[ch] : 1'b0;
      m_run[ch]   = rst_n ? n_run[ch] : 0;
    end
    m_w0 = rst_n && n_w0;
    m_w1 = rst_n && n_w1;
    m_c  = rst_n && n_c;
    check("model_w0", int'(w0), int'(m_w0));
    check("model_w1", int'(w1), int'(m_w1));
    check("model_conflict", int'(conflict), int'(m_c));
    check("onehot", int'($onehot0({w0, w1, conflict})), 1);
  endtask

  typedef struct {
    logic [31:0] m0;
    logic [31:0] m1;
    int          e_w0;
    int          e_w1;
    int          e_c;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int c0, c1, cc, first;

    vecs[0] = '{32'h000F_FFFF, 32'h0000_0000, 1, 0, 0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0007, 0, 0, 0};
    vecs[2] = '{32'h0000_03FF, 32'h0000_03FF, 0, 0, 1};
    vecs[3] = '{32'h3FFF_FC00, 32'h3FFF_FFFF, 0, 1, 1};
    vecs[4] = '{32'h0000_000F, 32'h0000_0000, 1, 0, 0};
    vecs[5] = '{32'h0000_00FC, 32'h0000_001F, 0, 0, 2};
    vecs[6] = '{32'h0000_0000, 32'h0000_0015, 0, 0, 0};
    vecs[7] = '{32'h00FF_00FF, 32'h0000_0000, 2, 0, 0};
    vecs[8] = '{32'h0003_FCFF, 32'h0000_0000, 1, 0, 0};
    vecs[9] = '{32'h7777_7777, 32'h0000_0000, 0, 0, 0};

    // Reset state, with a key held to show nothing propagates during reset.
    btn0 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("reset_w0", int'(w0), 0);
    check("reset_w1", int'(w1), 0);
    check("reset_conflict", int'(conflict), 0);
    btn0 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    for (int v = 0; v < 10; v++) begin
      c0 = 0;
      c1 = 0;
      cc = 0;
      for (int cyc = 0; cyc < 72; cyc++) begin
        btn0 = (cyc < 32) ? vecs[v].m0[cyc] : 1'b0;
        btn1 = (cyc < 32) ? vecs[v].m1[cyc] : 1'b0;
        tick();
        c0 += int'(w0);
        c1 += int'(w1);
        cc += int'(conflict);
      end
      check($sformatf("vec%0d_w0", v), c0, vecs[v].e_w0);
      check($sformatf("vec%0d_w1", v), c1, vecs[v].e_w1);
      check($sformatf("vec%0d_conflict", v), cc, vecs[v].e_c);
    end

    // Press latency: strobe appears after edge N+SYNC counting from the first edge seeing btn0=1.
    first = 0;
    btn0 = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (w0 && first == 0) first = e;
    end
    check("press_latency", first, N + SYNC);
    btn0 = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Reset mid-count discards progress; count restarts from reset release.
    btn0 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    #1;
    check("async_reset_w0", int'(w0), 0);
    for (int i = 0; i < 2; i++) tick();
    reset = 1'b1;
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (w0 && first == 0) first = e;
    end
    check("reset_restart_latency", first, N + SYNC);
    btn0 = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Random bouncing keys against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) btn0 = ~btn0;
      if ($urandom_range(0, 4) == 0) btn1 = ~btn1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioner for the digital lock. It turns two raw mechanical push-buttons into the clean, single-cycle `w0`/`w1` key strobes that the lock sequence FSM consumes. Each button is synchronised, debounced with a per-channel counter and edge-detected. Presses that overlap are rejected so the FSM never sees both keys in one cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive identical samples required to accept a level change. Legal range is 2 to 65535. Counter width is $clog2(DEBOUNCE_CYCLES).
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `btn0` input, 1 bit: raw key 0, active-high, possibly asynchronous and bouncing.
- `btn1` input, 1 bit: raw key 1, active-high, possibly asynchronous and bouncing.
- `w0` output, 1 bit: one-cycle strobe for an accepted key-0 press. Drives the lock FSM `w0`.
- `w1` output, 1 bit: one-cycle strobe for an accepted key-1 press. Drives the lock FSM `w1`.
- `conflict` output, 1 bit: one-cycle strobe when a press is rejected by arbitration.

## Operation
- Reset (`reset`=0) behaviour:
  - Sync flops, counters and channel states clear immediately.
  - Channels enter REL.
  - `w0`, `w1` and `conflict` are 0.
  - Reset asserted mid-count discards all partial progress. No strobe is emitted on reset exit.
- Per-channel FSM, operating on the synchronised sample `s`:
  - REL: stable released; counter=0. If `s`=1, go to PWAIT with counter=1.
  - PWAIT: if `s`=0, return to REL with counter=0. If `s`=1 and counter=DEBOUNCE_CYCLES-1, go to HELD and raise the qualify flag. Otherwise counter+1.
  - HELD: stable pressed; counter=0. If `s`=0, go to RWAIT with counter=1.
  - RWAIT: if `s`=1, return to HELD with counter=0. If `s`=0 and counter=DEBOUNCE_CYCLES-1, go to REL. Otherwise counter+1.
- A press is accepted only after DEBOUNCE_CYCLES consecutive 1-samples. A release is accepted only after DEBOUNCE_CYCLES consecutive 0-samples.
- Holding a key produces exactly one strobe, with no auto-repeat.
- Arbitration is applied to the qualify flags in the same cycle:
  - Only one channel qualifies and the other channel is in REL: emit that channel's strobe.
  - Both channels qualify in the same cycle: emit neither `w0` nor `w1`, and pulse `conflict`.
  - One channel qualifies while the other is in PWAIT, HELD or RWAIT: suppress the strobe and pulse `conflict`. The channel still moves to HELD, so there is no later retry.
- `w0` and `w1` are never high simultaneously. `w0`, `w1` and `conflict` are mutually exclusive.
- Counter arithmetic is unsigned. The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.

## Timing
- All outputs are registered and high for exactly one cycle per event.
- Press latency with the synchroniser compiled in:
  - `btn` rises before edge k and stays high.
  - The strobe is high in the cycle following edge k+DEBOUNCE_CYCLES+1.
- Press latency without the synchroniser: the strobe is high in the cycle following edge k+DEBOUNCE_CYCLES-1.
- A glitch shorter than DEBOUNCE_CYCLES sampled cycles produces no strobe and no `conflict`.
- Minimum spacing between two accepted presses on one channel is 2×DEBOUNCE_CYCLES cycles (press qualify plus release qualify).

## Configuration
- `KEY_DEBOUNCE_SYNC_EN` defined: each of `btn0` and `btn1` passes through a 2-flop synchroniser. The synchroniser flops reset to 0.
- `KEY_DEBOUNCE_SYNC_EN` undefined: `s` is taken directly from `btn0`/`btn1`, which must then be synchronous to `clk`. Latency drops by 2 cycles and behaviour is otherwise identical.

## Structure
- Shared lock package holds:
  - the channel-state encoding (REL=2'b00, PWAIT=2'b01, HELD=2'b10, RWAIT=2'b11);
  - the DEBOUNCE_CYCLES default.
- Sub-module `debounce_channel`, instantiated twice, covers the synchroniser, counter, 4-state FSM and qualify/state outputs.
- The top level holds the arbitration logic and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 with the synchroniser enabled.
- `btn0` high from edge 10 onward → `w0`=1 only in the cycle after edge 15; `w1`=0 and `conflict`=0 throughout.
- `btn1` toggles 1,0,1,0,1 on consecutive cycles, then stays 0 → no strobe on any output.
- `btn0` held for 50 cycles, released, then pressed again after 20 cycles → exactly two `w0` strobes.
- `btn0` and `btn1` rise on the same edge → `conflict` pulses once; `w0`=`w1`=0.
- `btn1` held, then `btn0` pressed 10 cycles later → one `w1` strobe, then one `conflict` strobe, and no `w0`.
- `reset` asserted while `btn0` has been high for 3 cycles, released after 2 cycles while `btn0` stays high → `w0` fires 6 cycles after the first edge following release.
